// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, word, and the hazard unit's state and redirect encodings.
package cpu_types_pkg;

   typedef logic [4:0]  regbits_t;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      HALTED  = 2'd2
   } hz_state_t;

   // Numeric order doubles as priority: branch outranks jr outranks jump.
   typedef enum logic [1:0] {
      R_NONE   = 2'd0,
      R_JUMP   = 2'd1,
      R_JR     = 2'd2,
      R_BRANCH = 2'd3
   } redir_t;

endpackage

// File: rtl/hazard_unit.sv
// Pipeline stall/flush/halt control for the five-stage core, with a deferred redirect latch.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_unit
   import cpu_types_pkg::*;
(
   input  logic     CLK,
   input  logic     nRST,
   input  logic     ihit,
   input  logic     dhit,
   input  logic     exmem_DRen,
   input  logic     exmem_DWen,
   input  logic     idex_DRen,
   input  regbits_t idex_rt,
   input  regbits_t ifid_rs,
   input  regbits_t ifid_rt,
   input  logic     ifid_uses_rt,
   input  logic     jump_id,
   input  logic     jr_ex,
   input  logic     br_taken,
   input  logic     halt_wb,
   output logic     pc_en,
   output logic     ifid_en,
   output logic     ifid_flush,
   output logic     idex_en,
   output logic     idex_flush,
   output logic     exmem_en,
   output logic     exmem_flush,
   output logic     memwb_en,
   output logic     redir_take,
`ifdef HAZARD_STATS_EN
   output word_t    stall_cycles,
   output word_t    flush_events,
`endif
   output logic     halted
);

   hz_state_t state_q, state_d;
   redir_t    redir_q, redir_d;
   redir_t    redir_in, redir_eff;
   logic      memstall, lduse;

   assign memstall = (exmem_DRen | exmem_DWen) & ~dhit;
   assign lduse    = idex_DRen & (idex_rt != '0) &
                     ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

   assign redir_in  = br_taken ? R_BRANCH : jr_ex ? R_JR : jump_id ? R_JUMP : R_NONE;
   assign redir_eff = (redir_in > redir_q) ? redir_in : redir_q;

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_flush  = 1'b0;
      exmem_en    = 1'b1;
      exmem_flush = 1'b0;
      memwb_en    = 1'b1;
      redir_take  = 1'b0;
      halted      = 1'b0;
      state_d     = RUN;
      redir_d     = redir_q;
      if (!nRST) begin
         // Hold every latch clear while reset is asserted.
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
         {ifid_flush, idex_flush, exmem_flush}         = '1;
         redir_d = R_NONE;
      end else if (state_q == HALTED || halt_wb) begin
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
         halted  = 1'b1;
         state_d = HALTED;
      end else if (memstall) begin
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
         redir_d = redir_eff;
         state_d = MEMWAIT;
      end else if (redir_eff != R_NONE) begin
         redir_take  = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = (redir_eff == R_BRANCH) || (redir_eff == R_JR);
         exmem_flush = (redir_eff == R_BRANCH);
         redir_d     = R_NONE;
      end else if (lduse) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (!ihit) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= RUN;
         redir_q <= R_NONE;
      end else begin
         state_q <= state_d;
         redir_q <= redir_d;
      end
   end

`ifdef HAZARD_STATS_EN
   word_t stall_q, flush_q;

   function automatic word_t sat_inc(input word_t v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_en && !halted) stall_q <= sat_inc(stall_q);
         if (redir_take)        flush_q <= sat_inc(flush_q);
      end
   end

   assign stall_cycles = stall_q;
   assign flush_events = flush_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: driver queues expected control vectors, monitor checks them.
module tb_hazard_unit;
   import cpu_types_pkg::*;

   logic     CLK = 1'b0;
   logic     nRST, ihit, dhit, exmem_DRen, exmem_DWen, idex_DRen;
   regbits_t idex_rt, ifid_rs, ifid_rt;
   logic     ifid_uses_rt, jump_id, jr_ex, br_taken, halt_wb;
   logic     pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic     exmem_en, exmem_flush, memwb_en, redir_take, halted;
`ifdef HAZARD_STATS_EN
   word_t    stall_cycles, flush_events;
`endif

   hazard_unit dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .exmem_DRen(exmem_DRen), .exmem_DWen(exmem_DWen),
      .idex_DRen(idex_DRen), .idex_rt(idex_rt),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .jump_id(jump_id), .jr_ex(jr_ex), .br_taken(br_taken), .halt_wb(halt_wb),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_en(idex_en), .idex_flush(idex_flush),
      .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en),
      .redir_take(redir_take),
`ifdef HAZARD_STATS_EN
      .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
      .halted(halted)
   );

   always #5 CLK = ~CLK;

   // Bit order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_en redir_take halted
   localparam logic [9:0] V_RST   = 10'b0010101000;
   localparam logic [9:0] V_RUN   = 10'b1101010100;
   localparam logic [9:0] V_STALL = 10'b0000000000;
   localparam logic [9:0] V_LDU   = 10'b0001110100;
   localparam logic [9:0] V_NOI   = 10'b0111010100;
   localparam logic [9:0] V_BR    = 10'b1111111110;
   localparam logic [9:0] V_JR    = 10'b1111110110;
   localparam logic [9:0] V_JMP   = 10'b1111010110;
   localparam logic [9:0] V_HALT  = 10'b0000000001;

   typedef struct {
      logic [9:0]  exp;
      string       name;
   } item_t;

   item_t q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   function automatic logic [9:0] dut_vec();
      return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
              exmem_en, exmem_flush, memwb_en, redir_take, halted};
   endfunction

   // Monitor: outputs are combinational, so each cycle presents one result at the falling edge.
   always @(negedge CLK) begin
      if (q.size() > 0) begin
         item_t it;
         it = q.pop_front();
         n_checks++;
         if (dut_vec() !== it.exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", it.name, dut_vec(), it.exp);
         end
      end
   end

   task automatic idle();
      ihit = 1'b1; dhit = 1'b0; exmem_DRen = 1'b0; exmem_DWen = 1'b0;
      idex_DRen = 1'b0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
      ifid_uses_rt = 1'b0; jump_id = 1'b0; jr_ex = 1'b0; br_taken = 1'b0; halt_wb = 1'b0;
   endtask

   task automatic cyc(input logic [9:0] exp, input string name);
      item_t it;
      it.exp  = exp;
      it.name = name;
      q.push_back(it);
      @(posedge CLK);
      #1;
   endtask

`ifdef HAZARD_STATS_EN
   task automatic chk32(input word_t got, input word_t want, input string name);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask
`endif

   initial begin
      nRST = 1'b0;
      idle();
      @(posedge CLK);
      #1;
      cyc(V_RST, "reset_a");
      cyc(V_RST, "reset_b");
      nRST = 1'b1;
      cyc(V_RUN, "run_after_reset");

      // Load-use on rs, then on rt, then with rt=0 and with rt unused.
      idex_DRen = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
      cyc(V_LDU, "lduse_rs");
      idle();
      cyc(V_RUN, "lduse_release");
      idex_DRen = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
      cyc(V_RUN, "lduse_r0");
      idex_rt = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9; ifid_uses_rt = 1'b1;
      cyc(V_LDU, "lduse_rt");
      ifid_uses_rt = 1'b0;
      cyc(V_RUN, "lduse_rt_unused");
      idle();

      // Memory stall with a branch arriving in its second cycle.
      exmem_DRen = 1'b1;
      cyc(V_STALL, "memwait_1");
      br_taken = 1'b1;
      cyc(V_STALL, "memwait_2_br");
      br_taken = 1'b0;
      cyc(V_STALL, "memwait_3");
      dhit = 1'b1;
      cyc(V_BR, "memwait_release_br");
      idle();
      cyc(V_RUN, "redir_cleared");

      // Jump and jr together resolve as jr.
      jump_id = 1'b1; jr_ex = 1'b1;
      cyc(V_JR, "jump_jr_together");
      idle();
      jump_id = 1'b1;
      cyc(V_JMP, "jump_only");
      idle();

      // Fetch miss alone, miss with branch, load-use with branch.
      ihit = 1'b0;
      cyc(V_NOI, "imiss");
      br_taken = 1'b1;
      cyc(V_BR, "imiss_with_br");
      idle();
      idex_DRen = 1'b1; idex_rt = 5'd4; ifid_rs = 5'd4; br_taken = 1'b1;
      cyc(V_BR, "lduse_with_br");
      idle();

      // Store stall deferring a jump, followed by a direct jr during release: jr outranks jump.
      exmem_DWen = 1'b1; jump_id = 1'b1;
      cyc(V_STALL, "store_stall_jump");
      jump_id = 1'b0; jr_ex = 1'b1; dhit = 1'b1;
      cyc(V_JR, "store_release_jr");
      idle();
      cyc(V_RUN, "after_store");

      // Halt is sticky until reset.
      halt_wb = 1'b1;
      cyc(V_HALT, "halt_enter");
      halt_wb = 1'b0;
      cyc(V_HALT, "halt_hold");
      br_taken = 1'b1;
      cyc(V_HALT, "halt_ignores_br");
      idle();
      nRST = 1'b0;
      cyc(V_RST, "halt_reset");
      nRST = 1'b1;
      cyc(V_RUN, "run_after_halt");

      // Reset mid-stall drops the deferred branch.
      exmem_DRen = 1'b1; br_taken = 1'b1;
      cyc(V_STALL, "stall_defer_br");
      idle();
      nRST = 1'b0;
      cyc(V_RST, "reset_mid_stall");
      nRST = 1'b1;
      cyc(V_RUN, "no_stale_redirect");

`ifdef HAZARD_STATS_EN
      nRST = 1'b0;
      cyc(V_RST, "stats_reset");
      nRST = 1'b1;
      chk32(stall_cycles, 32'd0, "stall_cycles_reset");
      chk32(flush_events, 32'd0, "flush_events_reset");
      ihit = 1'b0;
      for (int i = 0; i < 5; i++) cyc(V_NOI, "stats_imiss");
      ihit = 1'b1; br_taken = 1'b1;
      cyc(V_BR, "stats_br");
      idle();
      chk32(stall_cycles, 32'd5, "stall_cycles");
      chk32(flush_events, 32'd1, "flush_events");
`endif

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block for the five-stage MIPS core: the driving end of the `enable`/`flush` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and of the PC write enable. It consumes decoded fields leaving IF/ID and ID/EX and resolution signals from EX/MEM and MEM/WB. From these it generates stalls for instruction fetch, data memory waits and load-use hazards, flushes for taken branches and jumps, and the halt freeze. It holds a small FSM and a deferred-redirect latch so that a redirect coinciding with a memory stall is never lost.

## Interface
- No parameters; widths come from `cpu_types_pkg`.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, synchronous, active-low.
- `ihit` in 1: instruction cache returned the fetch this cycle.
- `dhit` in 1: data cache completed the MEM-stage access this cycle.
- `exmem_DRen`, `exmem_DWen` in 1: MEM stage holds a load/store.
- `idex_DRen` in 1: EX stage holds a load.
- `idex_rt` in 5: load destination register.
- `ifid_rs`, `ifid_rt` in 5: ID-stage source registers.
- `ifid_uses_rt` in 1: ID instruction reads rt as a source.
- `jump_id` in 1: J/JAL decoded in ID.
- `jr_ex` in 1: JR in EX.
- `br_taken` in 1: branch resolved taken at EX/MEM output.
- `halt_wb` in 1: HALT reached WB.
- `pc_en` out 1
- `ifid_en`, `ifid_flush` out 1
- `idex_en`, `idex_flush` out 1
- `exmem_en`, `exmem_flush` out 1
- `memwb_en` out 1
- `redir_take` out 1: PC mux must select the redirect target this cycle.
- `halted` out 1

## Operation
- FSM states: RUN, MEMWAIT, HALTED. `redir_q[1:0]` holds a deferred redirect class: 0 none, 1 jump, 2 jr, 3 branch.
- `memstall = (exmem_DRen|exmem_DWen) & ~dhit`.
- `lduse = idex_DRen & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt))`.
- Priority, highest first:
  1. HALTED or `halt_wb`: all `_en`=0, all `_flush`=0, `halted`=1; the next state is HALTED. Only reset leaves HALTED.
  2. `memstall`: all `_en`=0, no flush, `redir_take`=0. Any redirect input (branch over jr over jump) is written into `redir_q` if it outranks the current content. Next state is MEMWAIT.
  3. Redirect pending (inputs or `redir_q`; branch outranks jr outranks jump): `redir_take`=1, `pc_en`=1, all latches enabled.
     - Branch: flushes IF/ID, ID/EX and EX/MEM.
     - jr: flushes IF/ID and ID/EX.
     - Jump: flushes IF/ID only.
     - `redir_q` clears.
  4. `lduse`: `pc_en`=0, `ifid_en`=0, `idex_flush`=1; EX/MEM and MEM/WB advance. This inserts exactly one bubble.
  5. `~ihit`: `pc_en`=0, `ifid_flush`=1; downstream stages advance.
  6. Otherwise all `_en`=1, no flush.
- MEMWAIT→RUN on the first cycle with `dhit`. That cycle follows the RUN rules (3–6) with `redir_q` honoured.
- A flush and an enable asserted together mean the latch loads zeros.

## Timing
- All outputs are combinational from the current state, `redir_q` and inputs; zero-cycle latency to the latch inputs.
- State, `redir_q` and counters update on the `CLK` rising edge.
- Reset values (`nRST`=0 sampled at an edge):
  - State RUN, `redir_q`=0, counters 0.
  - While `nRST` is low: all `_en`=0, all `_flush`=1, `redir_take`=0, `halted`=0.
- Reset mid-MEMWAIT discards `redir_q`.
- Simultaneous `br_taken` and `lduse`: the redirect wins and no bubble is inserted (the dependent instruction is flushed anyway).
- Simultaneous `~ihit` and a redirect: the redirect wins. The PC is written and the stale fetch is abandoned.

## Configuration
- `HAZARD_STATS_EN` defined: adds outputs `stall_cycles` and `flush_events` (32-bit `word_t`), reset 0, saturating at 0xFFFFFFFF.
  - `stall_cycles` counts cycles with `pc_en`=0 outside HALTED.
  - `flush_events` counts cycles with `redir_take`=1.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- `cpu_types_pkg` gains `regbits_t` (5-bit), the enum `hz_state_t {RUN, MEMWAIT, HALTED}`, and the enum `redir_t {R_NONE, R_JUMP, R_JR, R_BRANCH}`.
- No sub-module; detection is combinational logic beside one `always_ff`.

## Test plan
- `idex_DRen`=1, `idex_rt`=8, `ifid_rs`=8, `ihit`=1 → one cycle `pc_en`=0, `ifid_en`=0, `idex_flush`=1; next cycle all `_en`=1. Repeat with `idex_rt`=0 → no stall.
- `exmem_DRen`=1, `dhit` low for 3 cycles → all `_en`=0 for 3 cycles, state MEMWAIT; on the 4th cycle `dhit`=1 → all `_en`=1.
- `br_taken`=1 during the 2nd cycle of that memory stall → `redir_take`=0 while stalled. On the `dhit` cycle, `redir_take`=1 with `ifid_flush`, `idex_flush` and `exmem_flush`=1, then `redir_q`=0.
- `jump_id`=1 and `jr_ex`=1 together → jr class: `ifid_flush`=1, `idex_flush`=1, `exmem_flush`=0.
- `halt_wb`=1 → `halted`=1 and all `_en`=0 permanently, including after `halt_wb` falls. Assert `nRST`=0 → state RUN, `halted`=0.
- With `HAZARD_STATS_EN`: 5 `~ihit` cycles plus one branch → `stall_cycles`=5, `flush_events`=1.
